// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode, funct and control-field encodings for the multicycle MIPS control unit
package mc_ctrl_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [3:0]  state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWR    = 4'd5;
  localparam state_t S_EXECUTE  = 4'd6;
  localparam state_t S_ALUWB    = 4'd7;
  localparam state_t S_BEQ      = 4'd8;
  localparam state_t S_BNE      = 4'd9;
  localparam state_t S_ADDIEXEC = 4'd10;
  localparam state_t S_ADDIWB   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic u1 op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational R-type funct to ALU control decode
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control FSM with memory wait counter
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_last;
  logic [2:0]      fn_alu, alu_q;
  logic            fn_valid;
  logic            is_load_q;
  logic            pcen_raw, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

  mc_alu_decoder u_alu_dec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .valid      (fn_valid)
  );

  assign state    = state_q;
  assign mem_last = (cnt_q == CW'(MEM_LAT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_last) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = is_load_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_last) state_d = S_MEMWB;
      S_MEMWR:    if (mem_last) state_d = S_FETCH;
      S_EXECUTE:  state_d = fn_valid ? S_ALUWB : S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Only memory states self-loop, so any state change clears the wait counter.
  assign cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      alu_q     <= ALU_ADD;
      is_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_EXECUTE) alu_q <= fn_alu;
      if (state_q == S_DECODE) is_load_q <= (op == OP_LW);
    end
  end

  always_comb begin
    pcen_raw     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REG;
    pcsrc        = PC_ALU;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alucontrol   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb     = SRCB_FOUR;
        irwrite_raw = mem_last;
        pcen_raw    = mem_last;
      end
      S_DECODE: begin
        alusrcb     = SRCB_IMMSH;
        illegal_raw = !op_supported(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca     = 1'b1;
        alucontrol  = fn_alu;
        illegal_raw = !fn_valid;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        alucontrol   = alu_q;
      end
      S_BEQ, S_BNE: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcen_raw   = (state_q == S_BEQ) ? zero : !zero;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc    = PC_JUMP;
        pcen_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked combinationally so nothing fires while reset is held.
  assign pcen     = reset & pcen_raw;
  assign memwrite = reset & memwrite_raw;
  assign irwrite  = reset & irwrite_raw;
  assign regwrite = reset & regwrite_raw;
  assign illegal  = reset & illegal_raw;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm at MEM_LAT 1 and 3
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, memwrite, irwrite, regwrite, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       regdst, memtoreg;
    logic [2:0] alu;
    logic       illegal;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst = 2'b00;
  logic [1:0] zero = 2'b00;
  logic [5:0] op [2];
  logic [5:0] funct [2];
  logic [1:0] pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst, memtoreg, illegal;
  logic [1:0] alusrcb [2];
  logic [1:0] pcsrc [2];
  logic [2:0] aluc [2];
  logic [3:0] st [2];

  obs_t  q0 [$];
  obs_t  q1 [$];
  string n0 [$];
  string n1 [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  mc_control_fsm #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(rst[0]), .op(op[0]), .funct(funct[0]), .zero(zero[0]),
    .pcen(pcen[0]), .memwrite(memwrite[0]), .irwrite(irwrite[0]), .regwrite(regwrite[0]),
    .iord(iord[0]), .alusrca(alusrca[0]), .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]),
    .regdst(regdst[0]), .memtoreg(memtoreg[0]), .alucontrol(aluc[0]), .illegal(illegal[0]),
    .state(st[0])
  );

  mc_control_fsm #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(rst[1]), .op(op[1]), .funct(funct[1]), .zero(zero[1]),
    .pcen(pcen[1]), .memwrite(memwrite[1]), .irwrite(irwrite[1]), .regwrite(regwrite[1]),
    .iord(iord[1]), .alusrca(alusrca[1]), .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]),
    .regdst(regdst[1]), .memtoreg(memtoreg[1]), .alucontrol(aluc[1]), .illegal(illegal[1]),
    .state(st[1])
  );

  function automatic obs_t e(logic [3:0] s, logic pc, logic mw, logic irw, logic rw, logic io,
                             logic asa, logic [1:0] asb, logic [1:0] pcs, logic rd, logic mtr,
                             logic [2:0] alu, logic ill);
    obs_t o;
    o.st = s; o.pcen = pc; o.memwrite = mw; o.irwrite = irw; o.regwrite = rw; o.iord = io;
    o.alusrca = asa; o.alusrcb = asb; o.pcsrc = pcs; o.regdst = rd; o.memtoreg = mtr;
    o.alu = alu; o.illegal = ill;
    return o;
  endfunction

  function automatic obs_t act(int i);
    obs_t o;
    o.st = st[i]; o.pcen = pcen[i]; o.memwrite = memwrite[i]; o.irwrite = irwrite[i];
    o.regwrite = regwrite[i]; o.iord = iord[i]; o.alusrca = alusrca[i]; o.alusrcb = alusrcb[i];
    o.pcsrc = pcsrc[i]; o.regdst = regdst[i]; o.memtoreg = memtoreg[i]; o.alu = aluc[i];
    o.illegal = illegal[i];
    return o;
  endfunction

  // Monitor: pops one expected vector per cycle per DUT, sampled mid-cycle.
  always @(negedge clk) begin
    obs_t x, a;
    string nm;
    if (q0.size() > 0) begin
      x = q0.pop_front(); nm = n0.pop_front(); a = act(0); n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL %s (lat1): got %05h expected %05h", nm, a, x);
      end
    end
    if (q1.size() > 0) begin
      x = q1.pop_front(); nm = n1.pop_front(); a = act(1); n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL %s (lat3): got %05h expected %05h", nm, a, x);
      end
    end
  end

  task automatic drive(int i, logic r, logic [5:0] o, logic [5:0] f, logic z, obs_t x, string nm);
    @(posedge clk);
    #1;
    rst[i] = r; op[i] = o; funct[i] = f; zero[i] = z;
    if (i == 0) begin q0.push_back(x); n0.push_back(nm); end
    else        begin q1.push_back(x); n1.push_back(nm); end
  endtask

  task automatic fetch(int i, int ml, logic [5:0] o, logic [5:0] f, logic z);
    for (int k = 0; k < ml; k++)
      drive(i, 1'b1, o, f, z,
            e(4'd0, k == ml-1, 0, k == ml-1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 3'b010, 0), "fetch");
  endtask

  task automatic decode(int i, logic [5:0] o, logic [5:0] f, logic z, logic ill);
    drive(i, 1'b1, o, f, z, e(4'd1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 3'b010, ill), "decode");
  endtask

  task automatic rtype(int i, int ml, logic [5:0] f, logic [2:0] alu, logic ok);
    fetch(i, ml, 6'b000000, f, 0);
    decode(i, 6'b000000, f, 0, 0);
    drive(i, 1'b1, 6'b000000, f, 0,
          e(4'd6, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, ok ? alu : 3'b010, !ok), "execute");
    if (ok)
      drive(i, 1'b1, 6'b000000, f, 0,
            e(4'd7, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, alu, 0), "aluwb");
  endtask

  task automatic memop(int i, int ml, logic load);
    logic [5:0] o;
    o = load ? 6'b100011 : 6'b101011;
    fetch(i, ml, o, 6'h05, 0);
    decode(i, o, 6'h05, 0, 0);
    drive(i, 1'b1, o, 6'h05, 0, e(4'd2, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b010, 0), "memadr");
    for (int k = 0; k < ml; k++)
      if (load) drive(i, 1'b1, o, 6'h05, 0,
                      e(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0), "memrd");
      else      drive(i, 1'b1, o, 6'h05, 0,
                      e(4'd5, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0), "memwr");
    if (load)
      drive(i, 1'b1, o, 6'h05, 0, e(4'd4, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 3'b010, 0), "memwb");
  endtask

  task automatic branch(int i, int ml, logic is_bne, logic z);
    logic [5:0] o;
    o = is_bne ? 6'b000101 : 6'b000100;
    fetch(i, ml, o, 6'h00, z);
    decode(i, o, 6'h00, z, 0);
    drive(i, 1'b1, o, 6'h00, z,
          e(is_bne ? 4'd9 : 4'd8, is_bne ? !z : z, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 3'b110, 0),
          is_bne ? "bne" : "beq");
  endtask

  task automatic addi(int i, int ml);
    fetch(i, ml, 6'b001000, 6'h11, 0);
    decode(i, 6'b001000, 6'h11, 0, 0);
    drive(i, 1'b1, 6'b001000, 6'h11, 0, e(4'd10, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b010, 0), "addiexec");
    drive(i, 1'b1, 6'b001000, 6'h11, 0, e(4'd11, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0), "addiwb");
  endtask

  task automatic jump(int i, int ml);
    fetch(i, ml, 6'b000010, 6'h00, 0);
    decode(i, 6'b000010, 6'h00, 0, 0);
    drive(i, 1'b1, 6'b000010, 6'h00, 0, e(4'd12, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 3'b010, 0), "jump");
  endtask

  initial begin
    op[0] = 6'h00; op[1] = 6'h00; funct[0] = 6'h00; funct[1] = 6'h00;
    // Held in reset: FETCH selects visible, every strobe forced low.
    drive(0, 1'b0, 6'h00, 6'h20, 0, e(4'd0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 3'b010, 0), "reset_lat1");
    drive(1, 1'b0, 6'h00, 6'h20, 0, e(4'd0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 3'b010, 0), "reset_lat3");

    rtype(0, 1, 6'b100000, 3'b010, 1);
    rtype(0, 1, 6'b100010, 3'b110, 1);
    rtype(0, 1, 6'b100100, 3'b000, 1);
    rtype(0, 1, 6'b100101, 3'b001, 1);
    rtype(0, 1, 6'b101010, 3'b111, 1);
    rtype(0, 1, 6'b000111, 3'b010, 0);
    memop(0, 1, 1);
    memop(0, 1, 0);
    branch(0, 1, 0, 1);
    branch(0, 1, 0, 0);
    branch(0, 1, 1, 0);
    branch(0, 1, 1, 1);
    addi(0, 1);
    jump(0, 1);
    fetch(0, 1, 6'b111111, 6'h00, 0);
    decode(0, 6'b111111, 6'h00, 0, 1);
    addi(0, 1);

    memop(1, 3, 1);
    rtype(1, 3, 6'b100000, 3'b010, 1);
    fetch(1, 3, 6'b101011, 6'h00, 0);
    decode(1, 6'b101011, 6'h00, 0, 0);
    drive(1, 1'b1, 6'b101011, 6'h00, 0, e(4'd2, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b010, 0), "sw_memadr");
    drive(1, 1'b1, 6'b101011, 6'h00, 0, e(4'd5, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0), "sw_memwr1");
    drive(1, 1'b0, 6'b101011, 6'h00, 0, e(4'd0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 3'b010, 0), "sw_reset_memwr2");
    jump(1, 3);
    addi(1, 3);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
